// File: rtl/mac_pkg.sv
// Shared definitions for the packed INT MAC datapath: lane layouts,
// accumulator width and the drain FSM state type.
package mac_pkg;

    localparam logic        MODE_INT8   = 1'b1;
    localparam logic        MODE_INT4   = 1'b0;

    localparam int unsigned ACC_W       = 128;
    localparam int unsigned LANE_W_INT8 = 32;
    localparam int unsigned LANE_W_INT4 = 16;
    localparam int unsigned LANES_INT8  = 4;
    localparam int unsigned LANES_INT4  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Index of the final lane for a given lane layout.
    function automatic logic [2:0] last_lane(input logic mode);
        return (mode == MODE_INT8) ? 3'(LANES_INT8 - 1) : 3'(LANES_INT4 - 1);
    endfunction

endpackage

// File: rtl/mac_lane_sel.sv
// Combinational lane extractor: picks one lane out of a packed accumulator
// word, sign-extends it to 32 bits and, when MAC_DRAIN_SAT_EN is defined,
// clamps it to the signed 8-bit range [-128, 127].
module mac_lane_sel
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0]       word,
    input  logic                   mode,
    input  logic [2:0]             lane,
    output logic [LANE_W_INT8-1:0] value
);

    logic [6:0]              idx32;
    logic [6:0]              idx16;
    logic [LANE_W_INT8-1:0]  ext;

    // Extract the addressed lane and sign-extend INT4-layout lanes from bit 15.
    always_comb begin
        idx32 = {lane[1:0], 5'b0};
        idx16 = {lane, 4'b0};
        if (mode == MODE_INT8) begin
            ext = word[idx32 +: LANE_W_INT8];
        end else begin
            ext = {{(LANE_W_INT8 - LANE_W_INT4){word[idx16 + 7'd15]}},
                   word[idx16 +: LANE_W_INT4]};
        end
    end

`ifdef MAC_DRAIN_SAT_EN
    // Clamp the sign-extended lane to the signed 8-bit range.
    always_comb begin
        if ($signed(ext) > 32'sd127) begin
            value = 32'h0000_007F;
        end else if ($signed(ext) < -32'sd128) begin
            value = 32'hFFFF_FF80;
        end else begin
            value = ext;
        end
    end
`else
    // Pass the full sign-extended lane through unchanged.
    always_comb begin
        value = ext;
    end
`endif

endmodule

// File: rtl/mac_acc_drain.sv
// Accumulator drain: latches one 128-bit packed accumulator word and emits
// its lanes one per handshake as sign-extended 32-bit values.
// Optional clamp to [-128, 127] when MAC_DRAIN_SAT_EN is defined.
module mac_acc_drain
    import mac_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [2:0]       out_lane,
    output logic             out_last,
    output logic [CNT_W-1:0] words_done
);

    drain_state_e     state;
    drain_state_e     state_d;
    logic [ACC_W-1:0] word_q;
    logic             mode_q;

    logic             fire;
    logic             last_fire;
    logic             accept;
    logic             advance;
    logic [2:0]       next_lane;

    logic [ACC_W-1:0] sel_word;
    logic             sel_mode;
    logic [2:0]       sel_lane;
    logic [31:0]      sel_value;

    // Handshake decode; a new word can enter on the cycle the last lane leaves.
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && out_last;
    assign advance   = fire && !out_last;
    assign in_ready  = !rst && ((state == IDLE) || last_fire);
    assign accept    = in_valid && in_ready;
    assign next_lane = out_lane + 3'd1;

    // The single lane selector serves both the incoming word (lane 0) and
    // the latched word (next lane), so out_data is registered ahead of use.
    assign sel_word  = accept ? in_data : word_q;
    assign sel_mode  = accept ? in_mode : mode_q;
    assign sel_lane  = accept ? 3'd0    : next_lane;

    mac_lane_sel u_lane_sel (
        .word  (sel_word),
        .mode  (sel_mode),
        .lane  (sel_lane),
        .value (sel_value)
    );

    // Next-state logic for the IDLE/DRAIN FSM.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = DRAIN;
            DRAIN:   if (last_fire) state_d = accept ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Word latch, lane counter, registered lane outputs and drained-word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            mode_q     <= MODE_INT4;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_lane   <= '0;
            out_last   <= 1'b0;
            words_done <= '0;
        end else begin
            out_valid <= (state_d == DRAIN);
            if (accept) begin
                word_q   <= in_data;
                mode_q   <= in_mode;
                out_lane <= '0;
                out_data <= sel_value;
                out_last <= 1'b0;
            end else if (advance) begin
                out_lane <= next_lane;
                out_data <= sel_value;
                out_last <= (next_lane == last_lane(mode_q));
            end
            if (last_fire) begin
                words_done <= words_done + CNT_W'(1);
            end
        end
    end

endmodule
